// File: rtl/period_meter.sv
// period_meter: measures the period and high time of an asynchronous square wave in clk cycles.
// Each completed rise-to-rise measurement is published with a one-cycle valid strobe.
module period_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_sig,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high,
  output logic             o_valid,
  output logic             o_timeout,
  output logic             o_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic cnt_full(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
    if (inc && (c != CNT_MAX)) begin
      return c + CNT_ONE;
    end
    return c;
  endfunction

  // Stage p0: synchronizer chain, plus a fill marker that tells when s reflects
  // real post-reset samples rather than the cleared chain.
  logic [SYNC_STAGES-1:0] sync_p0;
  logic [SYNC_STAGES-1:0] prime_p0;
  logic                   sig_p1;
  logic                   s;
  logic                   primed;
  logic                   rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0  <= '0;
      prime_p0 <= '0;
      sig_p1   <= 1'b0;
    end else begin
      sync_p0  <= {sync_p0[SYNC_STAGES-2:0], i_sig};
      prime_p0 <= {prime_p0[SYNC_STAGES-2:0], 1'b1};
      sig_p1   <= s;
    end
  end

  assign s      = sync_p0[SYNC_STAGES-1];
  assign primed = prime_p0[SYNC_STAGES-1];
  assign rise   = s & ~sig_p1;

  // Stage p1: measurement FSM and counters.
  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] hcnt_q;
  logic [CNT_W-1:0] hcnt_d;
  logic             publish;
  logic             timeout_set;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hcnt_d      = hcnt_q;
    publish     = 1'b0;
    timeout_set = 1'b0;
    if (!i_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (primed && !s) begin
            state_d = ARM;
          end
        end
        ARM: begin
          if (rise) begin
            state_d = MEAS;
            cnt_d   = CNT_ONE;
            hcnt_d  = CNT_ONE;
          end
        end
        MEAS: begin
          if (rise) begin
            publish = 1'b1;
            cnt_d   = CNT_ONE;
            hcnt_d  = CNT_ONE;
          end else if (cnt_full(cnt_q)) begin
            timeout_set = 1'b1;
            state_d     = IDLE;
          end else begin
            cnt_d  = sat_inc(cnt_q, 1'b1);
            hcnt_d = sat_inc(hcnt_q, s);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    cnt_q  <= cnt_d;
    hcnt_q <= hcnt_d;
  end

  // Stage p2: published results, strobe and status.
  logic [CNT_W-1:0] period_p2;
  logic [CNT_W-1:0] high_p2;
  logic             vld_p2;
  logic             timeout_p2;
  logic             busy_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      period_p2  <= '0;
      high_p2    <= '0;
      vld_p2     <= 1'b0;
      timeout_p2 <= 1'b0;
      busy_p2    <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_p2  <= publish;
      busy_p2 <= (state_d == MEAS);
      if (publish) begin
        period_p2  <= cnt_q;
        high_p2    <= hcnt_q;
        timeout_p2 <= 1'b0;
      end else if (timeout_set) begin
        timeout_p2 <= 1'b1;
      end
    end
  end

  assign o_period  = period_p2;
  assign o_high    = high_p2;
  assign o_valid   = vld_p2;
  assign o_timeout = timeout_p2;
  assign o_busy    = busy_p2;

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: table-driven waveforms, hand-written corner sequences and a
// randomized run scored against a segment-level model (period = high+low, high = high).
module tb_period_meter;

  localparam int SYNC = 2;

  logic        clk;
  logic        rst;
  logic        en;
  logic        sig;
  logic [15:0] p16;
  logic [15:0] h16;
  logic        v16;
  logic        t16;
  logic        b16;
  logic [7:0]  p8;
  logic [7:0]  h8;
  logic        v8;
  logic        t8;
  logic        b8;

  period_meter #(.CNT_W(16), .SYNC_STAGES(SYNC)) dut16 (
    .clk(clk), .rst(rst), .i_en(en), .i_sig(sig),
    .o_period(p16), .o_high(h16), .o_valid(v16), .o_timeout(t16), .o_busy(b16)
  );

  period_meter #(.CNT_W(8), .SYNC_STAGES(SYNC)) dut8 (
    .clk(clk), .rst(rst), .i_en(en), .i_sig(sig),
    .o_period(p8), .o_high(h8), .o_valid(v8), .o_timeout(t8), .o_busy(b8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int period;
    int high;
    int cyc;
  } meas_t;

  typedef struct {
    int hi;
    int lo;
    int reps;
    int exp_period;
    int exp_high;
    int exp_cnt;
  } vec_t;

  meas_t cap16[$];
  meas_t cap8[$];
  int    cycle;
  int    consec16;
  int    consec8;
  bit    prev_v16;
  bit    prev_v8;
  int    tests;
  int    failed;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    meas_t m;
    @(posedge clk);
    #1;
    cycle++;
    if (v16) begin
      m.period = int'(p16); m.high = int'(h16); m.cyc = cycle;
      cap16.push_back(m);
    end
    if (v8) begin
      m.period = int'(p8); m.high = int'(h8); m.cyc = cycle;
      cap8.push_back(m);
    end
    if (v16 && prev_v16) consec16++;
    if (v8 && prev_v8) consec8++;
    prev_v16 = v16;
    prev_v8  = v8;
  endtask

  task automatic seg(input bit val, input int n);
    sig = val;
    repeat (n) tick();
  endtask

  task automatic clear_caps();
    cap16.delete();
    cap8.delete();
    consec16 = 0;
    consec8  = 0;
  endtask

  task automatic do_reset(input bit lvl);
    rst = 1'b1;
    en  = 1'b1;
    sig = lvl;
    tick();
    tick();
    rst = 1'b0;
    clear_caps();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  vec_t  tbl[8];
  meas_t expq[$];
  int    rc[$];
  int    hs[$];
  int    ls[$];
  int    rise2;
  int    r3;
  int    h;
  int    l;

  initial begin
    tests = 0; failed = 0; cycle = 0;
    rst = 1'b1; en = 1'b0; sig = 1'b0;
    prev_v16 = 1'b0; prev_v8 = 1'b0;

    tbl[0] = '{100, 100, 3, 200, 100, 3};
    tbl[1] = '{1,   1,  10, 2,   1,   10};
    tbl[2] = '{30,  70,  3, 100, 30,  3};
    tbl[3] = '{1,   5,   4, 6,   1,   4};
    tbl[4] = '{7,   1,   4, 8,   7,   4};
    tbl[5] = '{200, 1,   2, 201, 200, 2};
    tbl[6] = '{1,   300, 2, 301, 1,   2};
    tbl[7] = '{2,   2,   5, 4,   2,   5};

    // reset state
    do_reset(1'b0);
    chk("rst_period16", int'(p16), 0);
    chk("rst_high16", int'(h16), 0);
    chk("rst_valid16", int'(v16), 0);
    chk("rst_timeout16", int'(t16), 0);
    chk("rst_busy16", int'(b16), 0);
    chk("rst_period8", int'(p8), 0);
    chk("rst_busy8", int'(b8), 0);

    // table-driven waveforms: reps+1 rises give reps strobes
    for (int r = 0; r < 8; r++) begin
      do_reset(1'b0);
      seg(1'b0, 5);
      rise2 = 0;
      for (int k = 0; k <= tbl[r].reps; k++) begin
        if (k == 1) rise2 = cycle;
        seg(1'b1, tbl[r].hi);
        seg(1'b0, tbl[r].lo);
      end
      seg(1'b0, 4);
      chk($sformatf("row%0d_count", r), cap16.size(), tbl[r].exp_cnt);
      for (int i = 0; i < tbl[r].exp_cnt; i++) begin
        if (i < cap16.size()) begin
          chk($sformatf("row%0d_period%0d", r, i), cap16[i].period, tbl[r].exp_period);
          chk($sformatf("row%0d_high%0d", r, i), cap16[i].high, tbl[r].exp_high);
        end
      end
      if (cap16.size() > 0)
        chk($sformatf("row%0d_latency", r), cap16[0].cyc, rise2 + 1 + SYNC);
      chk($sformatf("row%0d_consec", r), consec16, 0);
    end

    // line already high across reset: the fake edge must not be measured
    do_reset(1'b1);
    seg(1'b1, 50);
    chk("fake_busy", int'(b16), 0);
    for (int k = 0; k < 3; k++) begin
      seg(1'b1, 30);
      seg(1'b0, 70);
    end
    seg(1'b1, 5);
    chk("fake_count", cap16.size(), 2);
    if (cap16.size() > 0) begin
      chk("fake_period", cap16[0].period, 100);
      chk("fake_high", cap16[0].high, 30);
    end

    // CNT_W=8: period 255 reported, then timeout, then recovery at period 40
    do_reset(1'b0);
    seg(1'b0, 5);
    seg(1'b1, 100); seg(1'b0, 155);
    seg(1'b1, 100); seg(1'b0, 155);
    r3 = cycle;
    seg(1'b1, 100);
    chk("max_count8", cap8.size(), 2);
    chk("max_period8", int'(p8), 255);
    chk("max_high8", int'(h8), 100);
    chk("max_timeout8", int'(t8), 0);
    seg(1'b0, 157);
    chk("to_early_timeout8", int'(t8), 0);
    chk("to_early_busy8", int'(b8), 1);
    chk("to_early_cycle", cycle - r3, 257);
    tick();
    chk("to_timeout8", int'(t8), 1);
    chk("to_busy8", int'(b8), 0);
    chk("to_valid8", int'(v8), 0);
    chk("to_period8", int'(p8), 255);
    chk("to_high8", int'(h8), 100);
    seg(1'b0, 40);
    chk("to_sticky8", int'(t8), 1);
    for (int k = 0; k < 4; k++) begin
      seg(1'b1, 20);
      seg(1'b0, 20);
    end
    chk("rec_count8", cap8.size(), 5);
    if (cap8.size() == 5) begin
      chk("rec_period8", cap8[4].period, 40);
      chk("rec_high8", cap8[4].high, 20);
    end
    chk("rec_timeout8", int'(t8), 0);

    // i_en low for one cycle mid-period discards the partial count
    do_reset(1'b0);
    seg(1'b0, 5);
    seg(1'b1, 100); seg(1'b0, 100);
    seg(1'b1, 100); seg(1'b0, 50);
    en = 1'b0;
    tick();
    chk("abort_busy", int'(b16), 0);
    chk("abort_valid", int'(v16), 0);
    chk("abort_period", int'(p16), 200);
    en = 1'b1;
    seg(1'b0, 49);
    seg(1'b1, 100); seg(1'b0, 100);
    seg(1'b1, 100); seg(1'b0, 100);
    seg(1'b1, 10);
    chk("abort_count", cap16.size(), 3);
    if (cap16.size() == 3) begin
      chk("abort_period1", cap16[1].period, 200);
      chk("abort_high2", cap16[2].high, 100);
    end

    // reset while measuring
    chk("pre_rst_busy", int'(b16), 1);
    chk("pre_rst_period", int'(p16), 200);
    rst = 1'b1;
    tick();
    chk("midrst_period", int'(p16), 0);
    chk("midrst_high", int'(h16), 0);
    chk("midrst_valid", int'(v16), 0);
    chk("midrst_timeout", int'(t16), 0);
    chk("midrst_busy", int'(b16), 0);
    rst = 1'b0;

    // randomized segments against the segment-level model
    do_reset(1'b0);
    seg(1'b0, 3);
    expq.delete(); rc.delete(); hs.delete(); ls.delete();
    for (int i = 0; i < 40; i++) begin
      h = $urandom_range(1, 40);
      l = $urandom_range(1, 40);
      if ($urandom_range(0, 5) == 0) h = 1;
      if ($urandom_range(0, 5) == 0) l = 1;
      rc.push_back(cycle);
      hs.push_back(h);
      ls.push_back(l);
      seg(1'b1, h);
      seg(1'b0, l);
    end
    rc.push_back(cycle);
    seg(1'b1, 2);
    seg(1'b0, 4);
    for (int k = 0; k < 40; k++) begin
      meas_t m;
      m.period = hs[k] + ls[k];
      m.high   = hs[k];
      m.cyc    = rc[k+1] + 1 + SYNC;
      expq.push_back(m);
    end
    chk("rand_count", cap16.size(), expq.size());
    for (int k = 0; k < expq.size(); k++) begin
      if (k < cap16.size()) begin
        chk($sformatf("rand_period%0d", k), cap16[k].period, expq[k].period);
        chk($sformatf("rand_high%0d", k), cap16[k].high, expq[k].high);
        chk($sformatf("rand_cyc%0d", k), cap16[k].cyc, expq[k].cyc);
      end
    end
    chk("rand_consec", consec16, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
